controller: RTL and testbench
=============================

CONTROLLER -- requirements
Module: controller

Interface
REQ-001 Parameter DATA_WIDTH, default 24, filter result/pixel width in bits.
REQ-002 Parameter BUS_WIDTH, default 32, memory address width in bits.
REQ-003 Parameter NUM_PIXELS, default 16, pixels processed per run (≥1).
REQ-004 Parameter SRC_BASE, default 32'h0000_0000, first source pixel address.
REQ-005 Parameter DST_BASE, default 32'h0000_1000, first result address.
REQ-006 Control_CLK  in  1  single clock; all state updates on its rising edge.
REQ-007 Control_RST  in  1  asynchronous, active-low reset.
REQ-008 Control_STRT  in  1  start request, sampled in IDLE only.
REQ-009 Control_FDNE  in  1  filter-done, single-cycle or held; qualifies Control_FDATA.
REQ-010 Control_FDATA  in  DATA_WIDTH  filter result, valid when Control_FDNE=1.
REQ-011 Control_FEN  out  1  filter enable.
REQ-012 Control_MEMRW  out  2  memory command: 00 idle, 01 read, 10 write, 11 never driven.
REQ-013 Control_MEMADDR  out  BUS_WIDTH  memory address for the current command.
REQ-014 Control_DNE  out  1  run complete, one-cycle pulse.

Function
REQ-015 The FSM SHALL have states IDLE, READ, FILTER, WRITE, NEXT, DONE.
REQ-016 The pixel index idx SHALL be a counter of $clog2(NUM_PIXELS+1) bits, cleared in IDLE.
REQ-017 IDLE: all outputs 0; Control_STRT=1 -> READ on the next edge, idx=0.
REQ-018 READ, one cycle: MEMRW=01, MEMADDR=SRC_BASE+idx, FEN=0; -> FILTER.
REQ-019 FILTER: FEN=1, MEMRW=00, MEMADDR holds the last read address; stay until Control_FDNE=1, then capture Control_FDATA into a result register and -> WRITE.
REQ-020 WRITE, one cycle: MEMRW=10, MEMADDR=DST_BASE+idx, FEN=0; the captured result is held stable for the write.
REQ-021 NEXT, one cycle: MEMRW=00; if idx==NUM_PIXELS-1 -> DONE, else idx+1 and -> READ.
REQ-022 DONE, one cycle: Control_DNE=1, all other outputs 0; -> IDLE.
REQ-023 Address arithmetic SHALL be modulo 2^BUS_WIDTH; wrap-around is permitted and not flagged.
REQ-024 Control_STRT outside IDLE SHALL be ignored; a run cannot be restarted mid-operation.
REQ-025 Control_FDNE outside FILTER SHALL be ignored and SHALL NOT alter the result register.
REQ-026 FILTER SHALL wait indefinitely; there is no timeout.
REQ-027 STRT held high through DONE SHALL start a new run on the cycle after the return to IDLE.
REQ-028 Outputs SHALL be registered or decoded from registered state only, never combinationally from inputs.
REQ-029 Per pixel, latency SHALL be 3 cycles plus the FILTER wait; from an FDNE at idx=NUM_PIXELS-1 to DNE is 3 cycles.

Reset
REQ-030 Control_RST=0 SHALL asynchronously force IDLE, idx=0, result register=0, and FEN=0, MEMRW=00, MEMADDR=0, DNE=0.
REQ-031 Reset asserted mid-run SHALL abort the run without asserting DNE; after release the block waits for a new STRT.
REQ-032 Reset deassertion SHALL be treated as synchronous to Control_CLK by the integrator.

Structure
REQ-033 A shared package SHALL hold the state enum and the MEMRW encodings (MEM_IDLE, MEM_READ, MEM_WRITE).
REQ-034 A single sub-module, pixel_counter (index register with clear, increment and terminal-count flag), is natural; the FSM stays in controller.

Verification
REQ-035 Reset: RST=0 with random inputs -> all outputs 0 immediately, with no clock edge needed.
REQ-036 Single pixel with NUM_PIXELS=1: STRT pulse -> MEMRW=01 @0x0, then FEN=1; FDNE=1 with FDATA=24'hABCDEF -> MEMRW=10 @0x1000 one cycle later; DNE pulses 3 cycles after FDNE.
REQ-037 Full run with defaults and FDNE 10 cycles after each FEN rise -> reads 0x0..0xF and writes 0x1000..0x100F in order, with exactly one DNE.
REQ-038 Late FDNE: FDNE held 0 for 1000 cycles -> FEN stays 1 and MEMRW stays 00 throughout; no write occurs.
REQ-039 Spurious inputs: STRT and FDNE pulsed during READ/WRITE/NEXT -> no restart, no extra write, result unchanged.
REQ-040 Mid-run reset: RST=0 during pixel 5 FILTER -> IDLE, no DNE; a new STRT restarts from SRC_BASE.

Source files
------------

// File: rtl/controller_pkg.sv
// -----------------------------------------------------------------------------
// controller_pkg
// Shared definitions for the pixel-filter controller slice.
//   state_e   : controller FSM states
//   MEM_*     : encodings driven on Control_MEMRW (11 is never driven)
// -----------------------------------------------------------------------------
package controller_pkg;

  // One state per phase of a pixel transaction, plus idle and completion.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    FILTER = 3'd2,
    WRITE  = 3'd3,
    NEXT   = 3'd4,
    DONE   = 3'd5
  } state_e;

  // Memory command encodings.
  localparam logic [1:0] MEM_IDLE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

endpackage

// File: rtl/controller_pixel_counter.sv
// -----------------------------------------------------------------------------
// controller_pixel_counter
// Pixel index register for the controller. Cleared while the controller is
// idle, advanced once per completed pixel, and flags the final pixel.
//
// Ports
//   clk_i    : clock, rising edge active
//   rst_ni   : asynchronous active-low reset, clears the index
//   clear_i  : synchronous clear (takes priority over increment)
//   incr_i   : advance the index by one
//   idx_o    : current pixel index
//   last_o   : high when idx_o addresses the final pixel (NUM_PIXELS-1)
// -----------------------------------------------------------------------------
module controller_pixel_counter #(
  parameter int NUM_PIXELS = 16,
  parameter int IDX_W      = $clog2(NUM_PIXELS + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             incr_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             last_o
);

  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;

  // The terminal-count flag comes straight off the register so the
  // controller's decision in NEXT depends only on registered state.
  assign last_o = (idx_q == IDX_W'(NUM_PIXELS - 1));
  assign idx_o  = idx_q;

  // Clear wins over increment; increment is suppressed on the last pixel
  // so the index can never run past the end of the run.
  always_comb begin
    idx_d = idx_q;
    if (clear_i) begin
      idx_d = '0;
    end else if (incr_i && !last_o) begin
      idx_d = idx_q + IDX_W'(1);
    end
  end

  // Index register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/controller.sv
// -----------------------------------------------------------------------------
// controller
// Sequences a run of NUM_PIXELS pixels through an external filter: for each
// pixel it reads the source word, enables the filter and waits for its
// result, then writes the captured result to the destination area.
//
// Parameters
//   DATA_WIDTH : filter result / pixel width
//   BUS_WIDTH  : memory address width
//   NUM_PIXELS : pixels per run (>= 1)
//   SRC_BASE   : address of the first source pixel
//   DST_BASE   : address of the first result
//
// Ports
//   Control_CLK     in  : clock, rising edge active
//   Control_RST     in  : asynchronous active-low reset
//   Control_STRT    in  : start request, only honoured while idle
//   Control_FDNE    in  : filter done, qualifies Control_FDATA while filtering
//   Control_FDATA   in  : filter result
//   Control_FEN     out : filter enable
//   Control_MEMRW   out : memory command (00 idle, 01 read, 10 write)
//   Control_MEMADDR out : address for the current memory command
//   Control_DNE     out : one-cycle pulse when a run completes
//   Control_WDATA   out : captured filter result, the data for the write
// -----------------------------------------------------------------------------
module controller
  import controller_pkg::*;
#(
  parameter int                   DATA_WIDTH = 24,
  parameter int                   BUS_WIDTH  = 32,
  parameter int                   NUM_PIXELS = 16,
  parameter logic [BUS_WIDTH-1:0] SRC_BASE   = BUS_WIDTH'(32'h0000_0000),
  parameter logic [BUS_WIDTH-1:0] DST_BASE   = BUS_WIDTH'(32'h0000_1000)
) (
  input  logic                  Control_CLK,
  input  logic                  Control_RST,
  input  logic                  Control_STRT,
  input  logic                  Control_FDNE,
  input  logic [DATA_WIDTH-1:0] Control_FDATA,
  output logic                  Control_FEN,
  output logic [1:0]            Control_MEMRW,
  output logic [BUS_WIDTH-1:0]  Control_MEMADDR,
  output logic                  Control_DNE,
  output logic [DATA_WIDTH-1:0] Control_WDATA
);

  localparam int IDX_W = $clog2(NUM_PIXELS + 1);

  state_e                  state_q;
  state_e                  state_d;
  logic [DATA_WIDTH-1:0]   result_q;
  logic [DATA_WIDTH-1:0]   result_d;

  logic [IDX_W-1:0]        idx;
  logic                    idx_last;
  logic                    idx_clear;
  logic                    idx_incr;

  logic [BUS_WIDTH-1:0]    src_addr;
  logic [BUS_WIDTH-1:0]    dst_addr;

  // Addresses wrap modulo 2^BUS_WIDTH; overflow is deliberately silent.
  assign src_addr = SRC_BASE + BUS_WIDTH'(idx);
  assign dst_addr = DST_BASE + BUS_WIDTH'(idx);

  controller_pixel_counter #(
    .NUM_PIXELS (NUM_PIXELS),
    .IDX_W      (IDX_W)
  ) u_pixel_counter (
    .clk_i   (Control_CLK),
    .rst_ni  (Control_RST),
    .clear_i (idx_clear),
    .incr_i  (idx_incr),
    .idx_o   (idx),
    .last_o  (idx_last)
  );

  // Next-state and output decode. Outputs depend only on state_q and the
  // registered index, so no input ever reaches an output combinationally.
  // Start and filter-done are only looked at in the states that care about
  // them, which is what makes stray pulses elsewhere harmless.
  always_comb begin
    state_d         = state_q;
    result_d        = result_q;
    idx_clear       = 1'b0;
    idx_incr        = 1'b0;
    Control_FEN     = 1'b0;
    Control_MEMRW   = MEM_IDLE;
    Control_MEMADDR = '0;
    Control_DNE     = 1'b0;

    unique case (state_q)
      IDLE: begin
        idx_clear = 1'b1;
        if (Control_STRT) begin
          state_d = READ;
        end
      end

      READ: begin
        Control_MEMRW   = MEM_READ;
        Control_MEMADDR = src_addr;
        state_d         = FILTER;
      end

      // The read address is held so the source word stays addressed while
      // the filter works; there is no timeout on the wait.
      FILTER: begin
        Control_FEN     = 1'b1;
        Control_MEMADDR = src_addr;
        if (Control_FDNE) begin
          result_d = Control_FDATA;
          state_d  = WRITE;
        end
      end

      WRITE: begin
        Control_MEMRW   = MEM_WRITE;
        Control_MEMADDR = dst_addr;
        state_d         = NEXT;
      end

      NEXT: begin
        if (idx_last) begin
          state_d = DONE;
        end else begin
          idx_incr = 1'b1;
          state_d  = READ;
        end
      end

      DONE: begin
        Control_DNE = 1'b1;
        state_d     = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers. Reset abandons any run in progress and
  // clears the captured result.
  always_ff @(posedge Control_CLK or negedge Control_RST) begin
    if (!Control_RST) begin
      state_q  <= IDLE;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
    end
  end

  assign Control_WDATA = result_q;

endmodule

// File: tb/tb_controller.sv
// -----------------------------------------------------------------------------
// tb_controller
// Self-checking bench for controller. A 16-pixel instance covers full runs,
// stalls, stray inputs and mid-run reset; a 1-pixel instance covers the
// single-pixel timing and back-to-back starts.
// -----------------------------------------------------------------------------
module tb_controller;
  import controller_pkg::*;

  localparam int              DW  = 24;
  localparam int              BW  = 32;
  localparam logic [BW-1:0]   SRC = 32'h0000_0000;
  localparam logic [BW-1:0]   DST = 32'h0000_1000;

  typedef struct packed {
    logic [1:0]    rw;
    logic [BW-1:0] addr;
    logic [DW-1:0] data;
  } memEvent_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          rstN, strt, fdne, fen, dne;
  logic [DW-1:0] fdata, wdata;
  logic [1:0]    memrw;
  logic [BW-1:0] memaddr;

  logic          rstN1, strt1, fdne1, fen1, dne1;
  logic [DW-1:0] fdata1, wdata1;
  logic [1:0]    memrw1;
  logic [BW-1:0] memaddr1;

  controller #(.DATA_WIDTH(DW), .BUS_WIDTH(BW), .NUM_PIXELS(16), .SRC_BASE(SRC), .DST_BASE(DST)) dut (
    .Control_CLK(clock), .Control_RST(rstN), .Control_STRT(strt), .Control_FDNE(fdne),
    .Control_FDATA(fdata), .Control_FEN(fen), .Control_MEMRW(memrw), .Control_MEMADDR(memaddr),
    .Control_DNE(dne), .Control_WDATA(wdata));

  controller #(.DATA_WIDTH(DW), .BUS_WIDTH(BW), .NUM_PIXELS(1), .SRC_BASE(SRC), .DST_BASE(DST)) dutOne (
    .Control_CLK(clock), .Control_RST(rstN1), .Control_STRT(strt1), .Control_FDNE(fdne1),
    .Control_FDATA(fdata1), .Control_FEN(fen1), .Control_MEMRW(memrw1), .Control_MEMADDR(memaddr1),
    .Control_DNE(dne1), .Control_WDATA(wdata1));

  memEvent_t expQ[$];
  memEvent_t obsQ[$];
  int        dneCount = 0;
  int        compared = 0;
  int        mismatched = 0;

  function automatic memEvent_t mkEvent(input logic [1:0] rw, input logic [BW-1:0] addr, input logic [DW-1:0] data);
    memEvent_t e;
    e.rw = rw;
    e.addr = addr;
    e.data = data;
    return e;
  endfunction

  // Monitor: records every memory command of the 16-pixel instance and
  // counts completion pulses, sampled on the falling edge.
  always @(negedge clock) begin
    if (memrw == MEM_READ) obsQ.push_back(mkEvent(memrw, memaddr, '0));
    else if (memrw != MEM_IDLE) obsQ.push_back(mkEvent(memrw, memaddr, wdata));
    if (dne === 1'b1) dneCount++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Serves one pixel: expects its read, waits for the filter enable, then
  // returns a random result `delay` cycles later and expects its write.
  task automatic applyStimulus(input int p, input int delay, output bit timedOut);
    int waited = 0;
    logic [DW-1:0] d;
    timedOut = 1'b0;
    expQ.push_back(mkEvent(MEM_READ, SRC + BW'(p), '0));
    while (fen !== 1'b1 && waited < 50) begin tick(); waited++; end
    if (waited >= 50) begin timedOut = 1'b1; return; end
    repeat (delay) tick();
    d = DW'($urandom);
    fdne = 1'b1; fdata = d; tick(); fdne = 1'b0; fdata = DW'($urandom);
    expQ.push_back(mkEvent(MEM_WRITE, DST + BW'(p), d));
  endtask

  task automatic test_reset();
    rstN = 1'b0; rstN1 = 1'b0;
    strt = 1'($urandom); fdne = 1'($urandom); fdata = DW'($urandom);
    strt1 = 1'($urandom); fdne1 = 1'($urandom); fdata1 = DW'($urandom);
    #2;
    compared++; if (fen !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_fen: got %b want 0", fen); end
    compared++; if (memrw !== 2'b00) begin mismatched++; $display("[TB] FAIL reset_memrw: got %b want 00", memrw); end
    compared++; if (memaddr !== '0) begin mismatched++; $display("[TB] FAIL reset_memaddr: got %h want 0", memaddr); end
    compared++; if (dne !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_dne: got %b want 0", dne); end
    compared++; if (wdata !== '0) begin mismatched++; $display("[TB] FAIL reset_result: got %h want 0", wdata); end
    compared++; if ({fen1, memrw1, dne1} !== 4'b0) begin mismatched++; $display("[TB] FAIL reset_one_outputs: got %b want 0000", {fen1, memrw1, dne1}); end
    repeat (3) begin
      tick();
      strt = 1'($urandom); fdne = 1'($urandom); fdata = DW'($urandom);
    end
    compared++; if ({fen, memrw, dne} !== 4'b0 || memaddr !== '0) begin mismatched++; $display("[TB] FAIL reset_held: got fen/rw/dne=%b addr=%h want 0", {fen, memrw, dne}, memaddr); end
    strt = 1'b0; fdne = 1'b0; strt1 = 1'b0; fdne1 = 1'b0;
    rstN = 1'b1; rstN1 = 1'b1;
    tick();
    compared++; if (memrw !== MEM_IDLE) begin mismatched++; $display("[TB] FAIL reset_release_idle: got %b want 00", memrw); end
  endtask

  task automatic test_single_pixel();
    strt1 = 1'b1; tick(); strt1 = 1'b0;
    @(negedge clock);
    compared++; if (memrw1 !== MEM_READ || memaddr1 !== 32'h0 || fen1 !== 1'b0) begin mismatched++; $display("[TB] FAIL single_read: got rw=%b addr=%h fen=%b want 01/0/0", memrw1, memaddr1, fen1); end
    tick(); @(negedge clock);
    compared++; if (fen1 !== 1'b1 || memrw1 !== MEM_IDLE || memaddr1 !== 32'h0) begin mismatched++; $display("[TB] FAIL single_filter: got fen=%b rw=%b addr=%h want 1/00/0", fen1, memrw1, memaddr1); end
    tick();
    fdne1 = 1'b1; fdata1 = 24'hABCDEF; tick(); fdne1 = 1'b0; fdata1 = 24'h000000;
    @(negedge clock);
    compared++; if (memrw1 !== MEM_WRITE || memaddr1 !== 32'h1000 || wdata1 !== 24'hABCDEF) begin mismatched++; $display("[TB] FAIL single_write: got rw=%b addr=%h data=%h want 10/1000/abcdef", memrw1, memaddr1, wdata1); end
    tick(); @(negedge clock);
    compared++; if (dne1 !== 1'b0) begin mismatched++; $display("[TB] FAIL single_dne_early: got %b want 0", dne1); end
    tick(); @(negedge clock);
    compared++; if (dne1 !== 1'b1 || memrw1 !== MEM_IDLE || fen1 !== 1'b0) begin mismatched++; $display("[TB] FAIL single_dne: got dne=%b rw=%b fen=%b want 1/00/0", dne1, memrw1, fen1); end
    tick(); @(negedge clock);
    compared++; if (dne1 !== 1'b0) begin mismatched++; $display("[TB] FAIL single_dne_pulse: got %b want 0", dne1); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] expRw [6];
    logic       expDne [6];
    expRw  = '{MEM_READ, MEM_IDLE, MEM_WRITE, MEM_IDLE, MEM_IDLE, MEM_IDLE};
    expDne = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    strt1 = 1'b1; fdne1 = 1'b1; fdata1 = 24'h123456; tick();
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      compared++;
      if (memrw1 !== expRw[c % 6] || dne1 !== expDne[c % 6]) begin
        mismatched++;
        $display("[TB] FAIL b2b_cycle%0d: got rw=%b dne=%b want rw=%b dne=%b", c, memrw1, dne1, expRw[c % 6], expDne[c % 6]);
      end
      tick();
    end
    strt1 = 1'b0; fdne1 = 1'b0;
    rstN1 = 1'b0; tick(); rstN1 = 1'b1; tick();
  endtask

  task automatic test_full_run();
    int obsStart = obsQ.size();
    int dneStart = dneCount;
    int waited = 0;
    int k;
    bit to;
    memEvent_t e;
    expQ.delete();
    strt = 1'b1; tick(); strt = 1'b0;
    for (int p = 0; p < 16; p++) begin
      applyStimulus(p, 10, to);
      compared++; if (to) begin mismatched++; $display("[TB] FAIL full_run_fen_timeout: pixel %0d got no FEN want FEN", p); break; end
    end
    while (dneCount == dneStart && waited < 20) begin tick(); waited++; end
    repeat (5) tick();
    compared++; if (dneCount - dneStart != 1) begin mismatched++; $display("[TB] FAIL full_run_dne_count: got %0d want 1", dneCount - dneStart); end
    compared++; if (obsQ.size() - obsStart != expQ.size()) begin mismatched++; $display("[TB] FAIL full_run_event_count: got %0d want %0d", obsQ.size() - obsStart, expQ.size()); end
    k = obsStart;
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      if (k < obsQ.size()) begin
        compared++;
        if (obsQ[k] !== e) begin mismatched++; $display("[TB] FAIL full_run_event%0d: got rw=%b addr=%h data=%h want rw=%b addr=%h data=%h", k - obsStart, obsQ[k].rw, obsQ[k].addr, obsQ[k].data, e.rw, e.addr, e.data); end
      end
      k++;
    end
  endtask

  task automatic test_late_fdne();
    int obsStart = obsQ.size();
    int waited = 0;
    int bad = 0;
    logic [DW-1:0] d;
    strt = 1'b1; tick(); strt = 1'b0;
    while (fen !== 1'b1 && waited < 10) begin tick(); waited++; end
    compared++; if (waited >= 10) begin mismatched++; $display("[TB] FAIL late_fen_timeout: got no FEN want FEN"); end
    for (int c = 0; c < 1000; c++) begin
      @(negedge clock);
      if (fen !== 1'b1 || memrw !== MEM_IDLE) bad++;
    end
    compared++; if (bad != 0) begin mismatched++; $display("[TB] FAIL late_stall: got %0d bad cycles want 0", bad); end
    compared++; if (obsQ.size() - obsStart != 1) begin mismatched++; $display("[TB] FAIL late_no_write: got %0d events want 1", obsQ.size() - obsStart); end
    tick();
    d = DW'($urandom);
    fdne = 1'b1; fdata = d; tick(); fdne = 1'b0;
    @(negedge clock);
    compared++; if (memrw !== MEM_WRITE || memaddr !== DST || wdata !== d) begin mismatched++; $display("[TB] FAIL late_write: got rw=%b addr=%h data=%h want 10/%h/%h", memrw, memaddr, wdata, DST, d); end
    rstN = 1'b0; tick(); rstN = 1'b1; tick();
  endtask

  task automatic test_spurious();
    int obsStart;
    int dneStart;
    int waited = 0;
    int k;
    bit to;
    logic [DW-1:0] d0;
    memEvent_t e;
    rstN = 1'b0; tick(); rstN = 1'b1; tick();
    obsStart = obsQ.size(); dneStart = dneCount;
    expQ.delete();
    strt = 1'b1; tick(); strt = 1'b0;
    expQ.push_back(mkEvent(MEM_READ, SRC, '0));
    strt = 1'b1; fdne = 1'b1; fdata = 24'h5A5A5A; tick(); strt = 1'b0; fdne = 1'b0;
    @(negedge clock);
    compared++; if (fen !== 1'b1 || memrw !== MEM_IDLE || wdata !== '0) begin mismatched++; $display("[TB] FAIL spur_read: got fen=%b rw=%b result=%h want 1/00/0", fen, memrw, wdata); end
    repeat (2) tick();
    d0 = DW'($urandom);
    fdne = 1'b1; fdata = d0; tick();
    expQ.push_back(mkEvent(MEM_WRITE, DST, d0));
    strt = 1'b1; fdne = 1'b1; fdata = ~d0; tick();
    @(negedge clock);
    compared++; if (wdata !== d0) begin mismatched++; $display("[TB] FAIL spur_write_result: got %h want %h", wdata, d0); end
    tick(); strt = 1'b0; fdne = 1'b0;
    @(negedge clock);
    compared++; if (memrw !== MEM_READ || memaddr !== SRC + 32'd1 || wdata !== d0) begin mismatched++; $display("[TB] FAIL spur_next: got rw=%b addr=%h result=%h want 01/%h/%h", memrw, memaddr, wdata, SRC + 32'd1, d0); end
    for (int p = 1; p < 16; p++) begin
      applyStimulus(p, 2, to);
      compared++; if (to) begin mismatched++; $display("[TB] FAIL spur_fen_timeout: pixel %0d got no FEN want FEN", p); break; end
    end
    while (dneCount == dneStart && waited < 20) begin tick(); waited++; end
    repeat (5) tick();
    compared++; if (dneCount - dneStart != 1) begin mismatched++; $display("[TB] FAIL spur_dne_count: got %0d want 1", dneCount - dneStart); end
    compared++; if (obsQ.size() - obsStart != expQ.size()) begin mismatched++; $display("[TB] FAIL spur_event_count: got %0d want %0d", obsQ.size() - obsStart, expQ.size()); end
    k = obsStart;
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      if (k < obsQ.size()) begin
        compared++;
        if (obsQ[k] !== e) begin mismatched++; $display("[TB] FAIL spur_event%0d: got rw=%b addr=%h data=%h want rw=%b addr=%h data=%h", k - obsStart, obsQ[k].rw, obsQ[k].addr, obsQ[k].data, e.rw, e.addr, e.data); end
      end
      k++;
    end
  endtask

  task automatic test_mid_reset();
    int obsStart = obsQ.size();
    int dneStart = dneCount;
    int obsAtReset;
    int waited = 0;
    bit to;
    expQ.delete();
    strt = 1'b1; tick(); strt = 1'b0;
    for (int p = 0; p < 5; p++) begin
      applyStimulus(p, 1, to);
      compared++; if (to) begin mismatched++; $display("[TB] FAIL mid_fen_timeout: pixel %0d got no FEN want FEN", p); break; end
    end
    while (fen !== 1'b1 && waited < 10) begin tick(); waited++; end
    compared++; if (memaddr !== SRC + 32'd5) begin mismatched++; $display("[TB] FAIL mid_pixel5_addr: got %h want %h", memaddr, SRC + 32'd5); end
    compared++; if (obsQ.size() - obsStart != 11) begin mismatched++; $display("[TB] FAIL mid_event_count: got %0d want 11", obsQ.size() - obsStart); end
    #2 rstN = 1'b0;
    #1;
    compared++; if ({fen, memrw, dne} !== 4'b0 || memaddr !== '0 || wdata !== '0) begin mismatched++; $display("[TB] FAIL mid_async_reset: got fen/rw/dne=%b addr=%h result=%h want 0", {fen, memrw, dne}, memaddr, wdata); end
    obsAtReset = obsQ.size();
    tick(); tick(); rstN = 1'b1;
    repeat (5) tick();
    compared++; if (dneCount != dneStart) begin mismatched++; $display("[TB] FAIL mid_no_dne: got %0d pulses want 0", dneCount - dneStart); end
    compared++; if (obsQ.size() != obsAtReset) begin mismatched++; $display("[TB] FAIL mid_idle_after: got %0d events want 0", obsQ.size() - obsAtReset); end
    strt = 1'b1; tick(); strt = 1'b0;
    @(negedge clock);
    compared++; if (memrw !== MEM_READ || memaddr !== SRC) begin mismatched++; $display("[TB] FAIL mid_restart: got rw=%b addr=%h want 01/%h", memrw, memaddr, SRC); end
    rstN = 1'b0; tick(); rstN = 1'b1; tick();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] controller bench starting");
    test_reset();
    test_single_pixel();
    test_back_to_back();
    test_full_run();
    test_late_fdne();
    test_spurious();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
